// File: rtl/hist_seq_ctrl.sv
// hist_seq_ctrl: per-event sequencer that clears the histogram, streams hits into it,
// drains it and holds the maximum bin/count as a result until accepted.
module hist_seq_ctrl #(
  parameter int THETA_BINS   = 128,
  parameter int DRAIN_CYCLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  input  logic [7:0] hit_tdata,
  input  logic       hit_tvalid,
  input  logic       hit_tlast,
  output logic       hit_tready,
  output logic [7:0] hist_rbin_tdata,
  output logic       hist_rbin_tvalid,
  output logic       hist_enable,
  output logic       hist_reset_rbins,
  input  logic [6:0] hist_max_rbin,
  input  logic [3:0] hist_max_count,
  input  logic       hist_max_vld,
  output logic [6:0] res_rbin,
  output logic [3:0] res_count,
  output logic [7:0] res_nhits,
  output logic       res_empty,
  output logic       res_valid,
  input  logic       res_ready
);
  localparam int CW = $clog2(THETA_BINS + DRAIN_CYCLES + 2) + 1;
  typedef enum logic [2:0] {IDLE, CLEAR, FILL, DRAIN, DONE} state_t;
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic w_acc, w_cap;
  assign w_acc = hit_tvalid & hit_tready;
  assign w_cap = hist_max_vld & (r_state == FILL || r_state == DRAIN);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      busy             <= 1'b0;
      hit_tready       <= 1'b0;
      hist_rbin_tdata  <= '0;
      hist_rbin_tvalid <= 1'b0;
      hist_enable      <= 1'b0;
      hist_reset_rbins <= 1'b0;
      res_rbin         <= '0;
      res_count        <= '0;
      res_nhits        <= '0;
      res_empty        <= 1'b0;
      res_valid        <= 1'b0;
    end else begin
      hist_rbin_tvalid <= w_acc;
      if (w_acc) hist_rbin_tdata <= hit_tdata;
      // capture also lands on the cycle that leaves FILL or DRAIN
      if (w_cap) begin
        res_rbin  <= hist_max_rbin;
        res_count <= hist_max_count;
        res_empty <= 1'b0;
      end
      case (r_state)
        IDLE: if (start) begin
          r_state          <= CLEAR;
          r_cnt            <= '0;
          busy             <= 1'b1;
          hist_reset_rbins <= 1'b1;
          res_rbin         <= '0;
          res_count        <= '0;
          res_nhits        <= '0;
          res_empty        <= 1'b1;
        end
        CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(THETA_BINS + 1)) begin
            r_state          <= FILL;
            r_cnt            <= '0;
            hist_reset_rbins <= 1'b0;
            hist_enable      <= 1'b1;
            hit_tready       <= 1'b1;
          end
        end
        FILL: begin
          if (w_acc && !hit_tdata[7] && res_nhits != 8'hFF) res_nhits <= res_nhits + 1'b1;
          if (w_acc && hit_tlast) begin
            r_state    <= DRAIN;
            hit_tready <= 1'b0;
          end
        end
        DRAIN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(DRAIN_CYCLES - 1)) begin
            r_state     <= DONE;
            hist_enable <= 1'b0;
            res_valid   <= 1'b1;
          end
        end
        DONE: if (res_ready) begin
          r_state   <= IDLE;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hist_seq_ctrl.sv
// tb_hist_seq_ctrl: directed bench for hist_seq_ctrl with a small histogram model
// that feeds running-maximum updates back one cycle after each forwarded hit.
module tb_hist_seq_ctrl;
  logic clk, rst, start, busy;
  logic [7:0] hit_tdata;
  logic hit_tvalid, hit_tlast, hit_tready;
  logic [7:0] hist_rbin_tdata;
  logic hist_rbin_tvalid, hist_enable, hist_reset_rbins;
  logic [6:0] hist_max_rbin;
  logic [3:0] hist_max_count;
  logic hist_max_vld;
  logic [6:0] res_rbin;
  logic [3:0] res_count;
  logic [7:0] res_nhits;
  logic res_empty, res_valid, res_ready;
  int checks = 0, errors = 0;
  logic [3:0] hist [128];
  int maxc;
  logic pend_vld;
  logic [6:0] pend_b;
  logic [3:0] pend_c;
  bit model_en;
  logic [63:0] snap;

  hist_seq_ctrl #(.THETA_BINS(128), .DRAIN_CYCLES(6)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .hit_tdata(hit_tdata), .hit_tvalid(hit_tvalid), .hit_tlast(hit_tlast), .hit_tready(hit_tready),
    .hist_rbin_tdata(hist_rbin_tdata), .hist_rbin_tvalid(hist_rbin_tvalid),
    .hist_enable(hist_enable), .hist_reset_rbins(hist_reset_rbins),
    .hist_max_rbin(hist_max_rbin), .hist_max_count(hist_max_count), .hist_max_vld(hist_max_vld),
    .res_rbin(res_rbin), .res_count(res_count), .res_nhits(res_nhits),
    .res_empty(res_empty), .res_valid(res_valid), .res_ready(res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (!rst) chk("enable_reset_exclusive", {63'd0, hist_enable & hist_reset_rbins}, 64'd0);

  function automatic logic [63:0] hist_outs();
    return {44'd0, busy, hit_tready, hist_rbin_tdata, hist_rbin_tvalid, hist_enable, hist_reset_rbins};
  endfunction
  function automatic logic [63:0] res_outs();
    return {43'd0, res_rbin, res_count, res_nhits, res_empty, res_valid};
  endfunction

  task automatic step();
    if (model_en) begin
      hist_max_vld = pend_vld; hist_max_rbin = pend_b; hist_max_count = pend_c;
      pend_vld = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    hit_tdata = d; hit_tvalid = 1'b1; hit_tlast = last;
    step();
    hit_tvalid = 1'b0; hit_tlast = 1'b0;
    chk("fwd_valid", {63'd0, hist_rbin_tvalid}, 64'd1);
    chk("fwd_data", {56'd0, hist_rbin_tdata}, {56'd0, d});
    if (model_en && !d[7]) begin
      if (hist[d[6:0]] != 4'hF) hist[d[6:0]] = hist[d[6:0]] + 1'b1;
      if (int'(hist[d[6:0]]) > maxc) begin
        maxc = int'(hist[d[6:0]]);
        pend_vld = 1'b1; pend_b = d[6:0]; pend_c = hist[d[6:0]];
      end
    end
  endtask

  task automatic do_start();
    for (int i = 0; i < 128; i++) hist[i] = '0;
    maxc = 0; pend_vld = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("clear_entry", {61'd0, busy, hist_reset_rbins, hist_enable}, 64'b110);
    chk("clear_res", res_outs(), {43'd0, 7'd0, 4'd0, 8'd0, 1'b1, 1'b0});
    begin
      int n = 0;
      while (hist_reset_rbins && n < 300) begin step(); n++; end
      chk("clear_len", 64'(n), 64'd130);
    end
    chk("fill_entry", {62'd0, hit_tready, hist_enable}, 64'b11);
  endtask

  task automatic wait_done();
    int n = 0;
    chk("drain_ready", {63'd0, hit_tready}, 64'd0);
    while (!res_valid && n < 50) begin
      step(); n++;
      if (n == 1) chk("drain_no_fwd", {63'd0, hist_rbin_tvalid}, 64'd0);
    end
    chk("drain_len", 64'(n), 64'd6);
    chk("done_enable", {62'd0, hist_enable, busy}, 64'b01);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("accepted", {62'd0, res_valid, busy}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hit_tdata = '0; hit_tvalid = 1'b0; hit_tlast = 1'b0;
    hist_max_rbin = '0; hist_max_count = '0; hist_max_vld = 1'b0; res_ready = 1'b0;
    model_en = 1'b1; pend_vld = 1'b0; pend_b = '0; pend_c = '0; maxc = 0;
    #1;
    chk("rst_hist_outs", hist_outs(), 64'd0);
    chk("rst_res_outs", res_outs(), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(); step();
    chk("idle_outs", hist_outs(), 64'd0);
    res_ready = 1'b1; step(); res_ready = 1'b0;
    chk("idle_ready_ignored", {62'd0, busy, res_valid}, 64'd0);

    // normal event with a start pulse mid-FILL
    do_start();
    send(8'd5, 1'b0);
    send(8'd5, 1'b0);
    hit_tvalid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("fill_idle_no_fwd", {63'd0, hist_rbin_tvalid}, 64'd0);
    chk("start_in_fill", {61'd0, hit_tready, hist_reset_rbins, busy}, 64'b101);
    send(8'd9, 1'b0);
    send(8'd5, 1'b1);
    wait_done();
    chk("normal_res", res_outs(), {43'd0, 7'd5, 4'd3, 8'd4, 1'b0, 1'b1});
    snap = res_outs();
    hist_max_vld = 1'b1; hist_max_rbin = 7'd77; hist_max_count = 4'd15; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("backpressure_hold", res_outs(), snap);
    end
    hist_max_vld = 1'b0; start = 1'b0;
    accept();

    // invalid bins only
    do_start();
    send(8'h85, 1'b0);
    send(8'h90, 1'b1);
    wait_done();
    chk("invalid_res", res_outs(), {43'd0, 7'd0, 4'd0, 8'd0, 1'b1, 1'b1});
    accept();

    // max arriving only in the last DRAIN cycle
    model_en = 1'b0;
    do_start();
    send(8'd3, 1'b1);
    for (int i = 0; i < 5; i++) step();
    chk("late_still_drain", {62'd0, res_valid, hist_enable}, 64'b01);
    hist_max_vld = 1'b1; hist_max_rbin = 7'd42; hist_max_count = 4'd9;
    step();
    hist_max_vld = 1'b0;
    chk("late_max_res", res_outs(), {43'd0, 7'd42, 4'd9, 8'd1, 1'b0, 1'b1});
    accept();
    model_en = 1'b1;

    // 300 hits saturate the hit counter
    do_start();
    for (int i = 0; i < 299; i++) send(8'd1, 1'b0);
    send(8'd1, 1'b1);
    wait_done();
    chk("saturate_res", res_outs(), {43'd0, 7'd1, 4'd15, 8'd255, 1'b0, 1'b1});
    accept();

    // asynchronous reset mid-FILL
    do_start();
    send(8'd4, 1'b0);
    hit_tdata = 8'd6; hit_tvalid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_hist", hist_outs(), 64'd0);
    chk("async_rst_res", res_outs(), 64'd0);
    #2 rst = 1'b0;
    hit_tvalid = 1'b0; model_en = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("post_rst_idle", {61'd0, busy, res_valid, hit_tready}, 64'd0);
    chk("post_rst_res", res_outs(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hist_seq_ctrl.md
HIST_SEQ_CTRL -- requirements
Module: hist_seq_ctrl

Interface
REQ-001 Parameter THETA_BINS, default 128, number of histogram r-bins to clear.
REQ-002 Parameter DRAIN_CYCLES, default 6, cycles the histogram stays enabled after the last hit.
REQ-003 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-high.
REQ-005 Port start  in  1  one-cycle request to process a new event.
REQ-006 Port busy  out  1  high whenever state is not IDLE.
REQ-007 Ports hit_tdata in 8, hit_tvalid in 1, hit_tlast in 1, hit_tready out 1: hit stream; bit7 set marks an invalid bin; bits 6:0 are the r-bin.
REQ-008 Ports hist_rbin_tdata out 8, hist_rbin_tvalid out 1: bin stream to the histogram updater.
REQ-009 Ports hist_enable out 1, hist_reset_rbins out 1: histogram mode controls.
REQ-010 Ports hist_max_rbin in 7, hist_max_count in 4, hist_max_vld in 1: running-maximum updates from the histogram.
REQ-011 Ports res_rbin out 7, res_count out 4, res_nhits out 8, res_empty out 1, res_valid out 1, res_ready in 1: event result.

Function
REQ-012 The FSM shall have states IDLE, CLEAR, FILL, DRAIN and DONE, with all outputs registered.
REQ-013 IDLE: start=1 -> CLEAR next cycle, counter cleared; start in any other state shall be ignored.
REQ-014 CLEAR: hist_reset_rbins=1, hist_enable=0 for exactly THETA_BINS+2 cycles, then FILL; result registers shall clear on CLEAR entry.
REQ-015 FILL: hist_enable=1, hit_tready=1; a beat is accepted when hit_tvalid&hit_tready.
REQ-016 Each accepted beat shall appear one cycle later as hist_rbin_tdata=hit_tdata, hist_rbin_tvalid=1; hist_rbin_tvalid=0 in every other cycle.
REQ-017 Accepted beats with bit7=0 shall increment res_nhits, saturating at 255; beats with bit7=1 are forwarded but not counted.
REQ-018 An accepted beat with hit_tlast=1 shall move FILL -> DRAIN after that cycle; that beat is processed normally, and hit_tready=0 from the next cycle.
REQ-019 DRAIN: hist_enable=1, hit_tready=0 for DRAIN_CYCLES cycles, then DONE.
REQ-020 In FILL and DRAIN, hist_max_vld=1 shall load res_rbin<=hist_max_rbin and res_count<=hist_max_count; in other states it shall be ignored.
REQ-021 DONE: hist_enable=0, res_valid=1; res_* shall be stable while res_valid=1 and res_ready=0.
REQ-022 DONE with res_ready=1 -> IDLE next cycle, res_valid=0; res_ready outside DONE is ignored.
REQ-023 res_empty shall be 1 when no hist_max_vld was captured during the event (res_rbin=0, res_count=0).
REQ-024 hist_enable and hist_reset_rbins shall never both be 1.
REQ-025 Simultaneous hist_max_vld and the FILL->DRAIN or DRAIN->DONE transition: the capture shall still take effect.

Reset
REQ-026 rst=1 shall force IDLE immediately without waiting for clk, and drive all outputs to 0 (busy, hit_tready, hist_*, res_*), with counters at 0.
REQ-027 A rst asserted mid-event shall discard the event; after release, no result is produced until a new start.

Verification
REQ-028 Reset values: rst pulse in FILL -> every output reads 0 while rst=1, without waiting for a clk edge; busy stays 0 after release.
REQ-029 Clear timing: start at cycle 0 -> hist_reset_rbins high cycles 1..130 (THETA_BINS=128), hit_tready=1 from cycle 131.
REQ-030 Normal event: hits 5,5,9,5(tlast) with a histogram model -> res_rbin=5, res_count=3, res_nhits=4, res_empty=0, res_valid held until res_ready.
REQ-031 Invalid bins: hits 0x85,0x90(tlast) -> res_nhits=0, res_empty=1, both beats forwarded on hist_rbin_tdata.
REQ-032 Backpressure and ignores: res_ready held 0 for 20 cycles in DONE -> res_* unchanged; a start pulse during FILL -> no effect.
REQ-033 Late max: hist_max_vld arriving in the last DRAIN cycle is captured, and the 300-hit saturation case gives res_nhits=255.
